grayscale_stream_ctrl: RTL and testbench

//  Frame-level sequencer for the RGB565->grayscale datapath. Accepts 32-bit words of two RGB565 pixels
//  on a valid/ready stream and converts each pixel through two rgb565Grayscale instances.

---
 rtl/grayscale_stream_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_grayscale_stream_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/grayscale_stream_ctrl.sv
// grayscale_stream_ctrl: frame sequencer for the RGB565 -> grayscale datapath.
// Takes two RGB565 pixels per input word and packs four gray bytes per output word.
// The final output word of a frame carries outLast; done pulses once it is consumed.

// rgb565Grayscale: one pixel of RGB565 to an 8-bit gray value.
// Channels are widened by zero-filling the low bits, then weighted with
// (54R + 183G + 19B) >> 8 and truncated.
module rgb565Grayscale (
  input  logic [15:0] i_pixel,
  output logic [7:0]  o_gray
);
  logic [15:0] w_r8;
  logic [15:0] w_g8;
  logic [15:0] w_b8;
  logic [15:0] w_sum;

  assign w_r8  = {8'd0, i_pixel[15:11], 3'b000};
  assign w_g8  = {8'd0, i_pixel[10:5], 2'b00};
  assign w_b8  = {8'd0, i_pixel[4:0], 3'b000};
  // Largest possible sum is 64220, so 16 bits never overflow.
  assign w_sum = (w_r8 * 16'd54) + (w_g8 * 16'd183) + (w_b8 * 16'd19);
  assign o_gray = 8'(w_sum >> 8);
endmodule

module grayscale_stream_ctrl #(
  parameter int CNT_WIDTH = 20
) (
  input  logic                 clock,
  input  logic                 nReset,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] pixelCount,
  output logic                 busy,
  output logic                 done,
  input  logic                 inValid,
  input  logic [31:0]          inData,
  output logic                 inReady,
  output logic                 outValid,
  output logic [31:0]          outData,
  input  logic                 outReady,
  output logic                 outLast
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] C_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] C_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] C_TWO  = CNT_WIDTH'(2);

  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_WIDTH-1:0] r_remaining;
  logic [15:0]          r_half;
  logic                 r_half_full;
  logic [31:0]          r_out_data;
  logic                 r_out_valid;
  logic                 r_out_last;
  logic                 r_done;

  logic [7:0]           w_g0;
  logic [7:0]           w_g1;
  logic [7:0]           w_g1_eff;
  logic                 w_final;
  logic                 w_to_half;
  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_out_consume;
  logic [31:0]          w_out_word;

  rgb565Grayscale u_gray0 (.i_pixel(inData[31:16]), .o_gray(w_g0));
  rgb565Grayscale u_gray1 (.i_pixel(inData[15:0]),  .o_gray(w_g1));

  // A word is final when it holds the last one or two pixels of the frame.
  assign w_final       = (r_remaining <= C_TWO);
  assign w_to_half     = !r_half_full && !w_final;
  assign w_accept      = inValid && w_in_ready;
  assign w_out_consume = r_out_valid && outReady;
  // With one pixel left the second pixel of the word is outside the frame.
  assign w_g1_eff      = (r_remaining == C_ONE) ? 8'h00 : w_g1;
  assign w_out_word    = r_half_full ? {r_half, w_g0, w_g1_eff}
                                     : {w_g0, w_g1_eff, 16'h0000};

  // State register.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic for the IDLE -> RUN -> DRAIN -> IDLE frame sequence.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && (pixelCount != C_ZERO)) begin
          w_state_next = S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_accept && w_final) begin
          w_state_next = S_DRAIN;
        end else begin
          w_state_next = S_RUN;
        end
      end
      S_DRAIN: begin
        if (w_out_consume && r_out_last) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_DRAIN;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Input backpressure: parking into the half register needs no output slot.
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      S_RUN:   w_in_ready = w_to_half || !r_out_valid || outReady;
      default: w_in_ready = 1'b0;
    endcase
  end

  // Remaining-pixel counter and half-word register holding two parked gray bytes.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_remaining <= C_ZERO;
      r_half      <= 16'h0000;
      r_half_full <= 1'b0;
    end else if ((r_state == S_IDLE) && start && (pixelCount != C_ZERO)) begin
      r_remaining <= pixelCount;
      r_half      <= 16'h0000;
      r_half_full <= 1'b0;
    end else if (w_accept) begin
      r_remaining <= w_final ? C_ZERO : (r_remaining - C_TWO);
      if (w_to_half) begin
        r_half      <= {w_g0, w_g1};
        r_half_full <= 1'b1;
      end else begin
        r_half_full <= 1'b0;
      end
    end else begin
      r_remaining <= r_remaining;
    end
  end

  // Output register: loads one cycle after the handshake, holds while stalled.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_out_data  <= 32'h0000_0000;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_accept && !w_to_half) begin
      r_out_data  <= w_out_word;
      r_out_valid <= 1'b1;
      r_out_last  <= w_final;
    end else if (w_out_consume) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  // Done pulse: empty-frame start, or consumption of the last output word.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_done <= 1'b0;
    end else if ((r_state == S_IDLE) && start && (pixelCount == C_ZERO)) begin
      r_done <= 1'b1;
    end else if ((r_state == S_DRAIN) && w_out_consume && r_out_last) begin
      r_done <= 1'b1;
    end else begin
      r_done <= 1'b0;
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign inReady  = w_in_ready;
  assign outValid = r_out_valid;
  assign outData  = r_out_data;
  assign outLast  = r_out_last;

endmodule

// File: tb/tb_grayscale_stream_ctrl.sv
// Directed bench for grayscale_stream_ctrl with hand-computed gray values:
// 0xFFFF->FA, 0xF800->34, 0x07E0->B4, 0x001F->12, 0x0000->00.
module tb_grayscale_stream_ctrl;
  localparam int CW = 20;

  logic          clock;
  logic          nReset;
  logic          start;
  logic [CW-1:0] pixelCount;
  logic          busy;
  logic          done;
  logic          inValid;
  logic [31:0]   inData;
  logic          inReady;
  logic          outValid;
  logic [31:0]   outData;
  logic          outReady;
  logic          outLast;

  int n_pass;
  int n_total;

  grayscale_stream_ctrl #(.CNT_WIDTH(CW)) dut (
    .clock(clock), .nReset(nReset), .start(start), .pixelCount(pixelCount),
    .busy(busy), .done(done), .inValid(inValid), .inData(inData),
    .inReady(inReady), .outValid(outValid), .outData(outData),
    .outReady(outReady), .outLast(outLast)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock and settle past the edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic begin_frame(input logic [CW-1:0] cnt);
    start = 1'b1;
    pixelCount = cnt;
    cyc();
    start = 1'b0;
    pixelCount = 20'd7;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    nReset = 1'b0;
    start = 1'b0;
    pixelCount = 20'd0;
    inValid = 1'b0;
    inData = 32'h0;
    outReady = 1'b1;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_inready", {31'd0, inReady}, 32'd0);
    chk("rst_outvalid", {31'd0, outValid}, 32'd0);
    chk("rst_outlast", {31'd0, outLast}, 32'd0);
    chk("rst_outdata", outData, 32'h0);
    cyc();
    nReset = 1'b1;
    cyc();

    // T1: 4 pixels in two words -> one output word
    begin_frame(20'd4);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    inValid = 1'b1;
    inData = 32'hFFFF_0000;
    #1;
    chk("t1_inready", {31'd0, inReady}, 32'd1);
    cyc();
    chk("t1_no_out_yet", {31'd0, outValid}, 32'd0);
    inData = 32'hF800_001F;
    cyc();
    inValid = 1'b0;
    chk("t1_outvalid", {31'd0, outValid}, 32'd1);
    chk("t1_outdata", outData, 32'hFA00_3412);
    chk("t1_outlast", {31'd0, outLast}, 32'd1);
    chk("t1_drain_inready", {31'd0, inReady}, 32'd0);
    chk("t1_done_early", {31'd0, done}, 32'd0);
    cyc();
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_idle", {31'd0, busy}, 32'd0);
    chk("t1_outvalid_clr", {31'd0, outValid}, 32'd0);
    cyc();
    chk("t1_done_pulse", {31'd0, done}, 32'd0);

    // T2: odd count, fourth pixel padded
    begin_frame(20'd3);
    inValid = 1'b1;
    inData = 32'h07E0_FFFF;
    cyc();
    inData = 32'h0000_FFFF;
    cyc();
    inValid = 1'b0;
    chk("t2_outdata", outData, 32'hB4FA_0000);
    chk("t2_outlast", {31'd0, outLast}, 32'd1);
    cyc();
    chk("t2_done", {31'd0, done}, 32'd1);
    cyc();

    // T3: output stall with input still offered
    begin_frame(20'd8);
    start = 1'b1;
    pixelCount = 20'd0;
    inValid = 1'b1;
    inData = 32'hFFFF_FFFF;
    cyc();
    start = 1'b0;
    cyc();
    chk("t3_first_out", outData, 32'hFAFA_FAFA);
    chk("t3_first_notlast", {31'd0, outLast}, 32'd0);
    outReady = 1'b0;
    #1;
    chk("t3_park_ready", {31'd0, inReady}, 32'd1);
    cyc();
    chk("t3_stall_ready", {31'd0, inReady}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t3_hold_valid", {31'd0, outValid}, 32'd1);
      chk("t3_hold_data", outData, 32'hFAFA_FAFA);
      chk("t3_hold_last", {31'd0, outLast}, 32'd0);
      chk("t3_hold_ready", {31'd0, inReady}, 32'd0);
      chk("t3_no_done", {31'd0, done}, 32'd0);
    end
    outReady = 1'b1;
    #1;
    chk("t3_release_ready", {31'd0, inReady}, 32'd1);
    cyc();
    inValid = 1'b0;
    chk("t3_second_valid", {31'd0, outValid}, 32'd1);
    chk("t3_second_data", outData, 32'hFAFA_FAFA);
    chk("t3_second_last", {31'd0, outLast}, 32'd1);
    cyc();
    chk("t3_done", {31'd0, done}, 32'd1);
    cyc();

    // T4: full throughput, four words back-to-back
    begin_frame(20'd8);
    inValid = 1'b1;
    inData = 32'hFFFF_0000;
    #1;
    chk("t4_ready_w1", {31'd0, inReady}, 32'd1);
    cyc();
    inData = 32'hF800_001F;
    chk("t4_ready_w2", {31'd0, inReady}, 32'd1);
    cyc();
    inData = 32'h07E0_FFFF;
    chk("t4_ready_w3", {31'd0, inReady}, 32'd1);
    chk("t4_out1_data", outData, 32'hFA00_3412);
    chk("t4_out1_last", {31'd0, outLast}, 32'd0);
    cyc();
    inData = 32'h001F_0000;
    chk("t4_ready_w4", {31'd0, inReady}, 32'd1);
    chk("t4_out1_gone", {31'd0, outValid}, 32'd0);
    cyc();
    inValid = 1'b0;
    chk("t4_out2_valid", {31'd0, outValid}, 32'd1);
    chk("t4_out2_data", outData, 32'hB4FA_1200);
    chk("t4_out2_last", {31'd0, outLast}, 32'd1);
    cyc();
    chk("t4_done", {31'd0, done}, 32'd1);
    cyc();

    // T5: empty frame
    begin_frame(20'd0);
    chk("t5_done", {31'd0, done}, 32'd1);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_outvalid", {31'd0, outValid}, 32'd0);
    cyc();
    chk("t5_done_pulse", {31'd0, done}, 32'd0);

    // T6: reset mid-frame, then a fresh two-pixel frame
    begin_frame(20'd8);
    inValid = 1'b1;
    inData = 32'hFFFF_FFFF;
    cyc();
    chk("t6_busy_before", {31'd0, busy}, 32'd1);
    nReset = 1'b0;
    #1;
    chk("t6_abort_busy", {31'd0, busy}, 32'd0);
    chk("t6_abort_ready", {31'd0, inReady}, 32'd0);
    chk("t6_abort_valid", {31'd0, outValid}, 32'd0);
    inValid = 1'b0;
    cyc();
    chk("t6_no_done", {31'd0, done}, 32'd0);
    nReset = 1'b1;
    cyc();
    begin_frame(20'd2);
    inValid = 1'b1;
    inData = 32'h001F_0000;
    cyc();
    inValid = 1'b0;
    chk("t6_outdata", outData, 32'h1200_0000);
    chk("t6_outlast", {31'd0, outLast}, 32'd1);
    cyc();
    chk("t6_done", {31'd0, done}, 32'd1);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
